// File: rtl/shift_add_mult16.sv
// Sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product (feeds the 16-bit datapath register).
// Latency: WIDTH RUN cycles + 1 DONE cycle (9 cycles from accept to load_en at WIDTH=8).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
// Optional macro SHIFT_ADD_MULT_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module shift_add_mult16 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               load_en,
  output logic [2*WIDTH-1:0] product
);

  // cnt must be able to hold WIDTH, the value it reaches after the last step
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [2*WIDTH-1:0]   mcand, mcand_nxt;
  logic [WIDTH-1:0]     mplier, mplier_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2*WIDTH-1:0]   product_nxt;
  logic [2*WIDTH-1:0]   addend;
  logic                 last;

  // Next-state and datapath: accept in IDLE, one partial product per RUN cycle, publish on DONE entry
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    cnt_nxt     = cnt;
    product_nxt = product;
    addend      = mplier[0] ? (mcand << cnt) : '0;
    last        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          mcand_nxt  = {{WIDTH{1'b0}}, a};
          mplier_nxt = b;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        acc_nxt    = acc + addend;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CW'(1);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        last       = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
`else
        last       = (cnt == CNT_LAST);
`endif
        if (last) begin
          // product must include this final step so it is valid alongside load_en
          product_nxt = acc_nxt;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; outputs are registered from the next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      load_en <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      cnt     <= cnt_nxt;
      product <= product_nxt;
      busy    <= (state_nxt != IDLE);
      load_en <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_shift_add_mult16.sv
// Testbench for shift_add_mult16 (default build, fixed WIDTH RUN cycles).
module tb_shift_add_mult16;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           load_en;
  logic [2*W-1:0] product;

  int checks;
  int errors;
  int exp_prod;

  shift_add_mult16 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .load_en (load_en),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply: reference result is plain a*b; load_en expected only after the W-th RUN edge.
  // With disturb set, operands are scrambled and start is pulsed during RUN.
  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input bit disturb);
    int p;
    p = int'(ra) * int'(rb);
    a = ra;
    b = rb;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_load", 32'(load_en), 32'd0);
    for (int k = 1; k <= W; k++) begin
      if (disturb) begin
        a = W'($urandom);
        b = W'($urandom);
        start = (k == 2);
      end
      tick();
      if (k < W) begin
        chk("run_load", 32'(load_en), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_prod_held", 32'(product), 32'(exp_prod));
      end else begin
        chk("done_load", 32'(load_en), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_prod", 32'(product), 32'(p));
        exp_prod = p;
      end
    end
    start = 1'b0;
    tick();
    chk("post_load", 32'(load_en), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_prod", 32'(product), 32'(exp_prod));
  endtask

  initial begin
    int pulses[$];
    checks   = 0;
    errors   = 0;
    exp_prod = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // reset for two cycles
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load", 32'(load_en), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_load", 32'(load_en), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // directed operand patterns
    run_op(8'd13, 8'd11, 1'b0);
    chk("p13x11", 32'(product), 32'h008F);
    run_op(8'd255, 8'd255, 1'b0);
    chk("p255x255", 32'(product), 32'hFE01);
    run_op(8'd0, 8'd200, 1'b0);
    chk("p0x200", 32'(product), 32'h0000);
    run_op(8'd3, 8'd5, 1'b1);
    chk("p3x5_ignored_start", 32'(product), 32'h000F);
    tick();
    chk("no_queued_op", 32'(busy), 32'd0);

    // start held high: back-to-back results every W+2 cycles
    a = 8'd17;
    b = 8'd19;
    start = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (load_en) begin
        pulses.push_back(t);
        chk("b2b_prod", 32'(product), 32'd323);
      end
    end
    start = 1'b0;
    exp_prod = 323;
    chk("b2b_count", 32'(pulses.size()), 32'd4);
    for (int i = 0; i < pulses.size(); i++)
      chk("b2b_time", 32'(pulses[i]), 32'(W + 1 + i * (W + 2)));
    for (int i = 0; i < W + 3; i++) tick();
    chk("b2b_drained", 32'(busy), 32'd0);

    // reset mid-operation aborts
    a = 8'd200;
    b = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_load", 32'(load_en), 32'd0);
    chk("abort_prod", 32'(product), 32'd0);
    exp_prod = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      chk("abort_no_pulse", 32'(load_en), 32'd0);
    end
    run_op(8'd6, 8'd7, 1'b0);
    chk("p6x7", 32'(product), 32'h002A);

    // randomized operands against a*b
    for (int i = 0; i < 16; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
